// File: rtl/counter_pkg.sv
// Shared definitions for the counter block: the default width and the
// binary-to-Gray helper that both the encoder and the reference model use.
package counter_pkg;

  // Default width of value/gray
  localparam int unsigned COUNTER_WIDTH = 32'd4;

  // Width the Gray helper works at; callers zero-extend into it and slice out
  localparam int unsigned GRAY_FN_WIDTH = 32'd32;

  // Gray code of a binary number: each bit XORed with its next-higher neighbour
  function automatic logic [GRAY_FN_WIDTH-1:0] bin2gray(input logic [GRAY_FN_WIDTH-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/counter_gray_enc.sv
// Combinational binary-to-Gray encoder used to drive the gray output of the counter.
module counter_gray_enc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  logic [GRAY_FN_WIDTH-1:0] w_gray_full;

  // The helper works at a fixed width, so widen the input and take the low bits back
  assign w_gray_full = bin2gray(GRAY_FN_WIDTH'(i_bin));
  assign o_gray      = w_gray_full[WIDTH-1:0];

  // Upper bits of the widened result are always zero; fold them away explicitly
  if (WIDTH < GRAY_FN_WIDTH) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_gray_full[GRAY_FN_WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/counter.sv
// Free-running up-counter: counts STEP per clock, wraps modulo MAX+1, clears
// asynchronously while reset is low, and exposes a terminal-count flag and a
// Gray-coded copy of the count. The port order (value, clk, reset, ...) keeps
// older three-port positional instances legal.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = COUNTER_WIDTH,
  parameter int unsigned MAX         = (32'd1 << WIDTH) - 32'd1,
  parameter int unsigned STEP        = 32'd1,
  parameter int unsigned RESET_VALUE = 32'd0
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset,
  output logic             tc,
  output logic [WIDTH-1:0] gray
);

  // Parameter limits: a bad combination stops elaboration
  if (WIDTH == 32'd0 || WIDTH > 32'd31) begin : g_bad_width
    $fatal(1, "counter: WIDTH must be in 1..31");
  end
  if (MAX >= (32'd1 << WIDTH)) begin : g_bad_max
    $fatal(1, "counter: MAX must be below 2**WIDTH");
  end
  if (STEP == 32'd0 || STEP > MAX) begin : g_bad_step
    $fatal(1, "counter: STEP must satisfy 1 <= STEP <= MAX");
  end
  if (RESET_VALUE > MAX) begin : g_bad_reset_value
    $fatal(1, "counter: RESET_VALUE must not exceed MAX");
  end

  // Arithmetic constants, one bit wider than the count so the sum cannot overflow
  localparam logic [WIDTH:0]   C_MAX   = (WIDTH + 1)'(MAX);
  localparam logic [WIDTH:0]   C_STEP  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   C_MOD   = C_MAX + {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] C_MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] C_RESET = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrapped;
  logic [WIDTH-1:0] w_next;
  logic             w_unused_carry;

  assign w_sum = {1'b0, r_value} + C_STEP;

  // Next count: advance by STEP and fold back into 0..MAX once the sum passes MAX
  always_comb begin
    w_wrapped = w_sum;
    if (w_sum > C_MAX) begin
      w_wrapped = w_sum - C_MOD;
    end else begin
      w_wrapped = w_sum;
    end
  end

  // The wrapped result is always <= MAX, so its top bit carries nothing
  assign w_next         = w_wrapped[WIDTH-1:0];
  assign w_unused_carry = w_wrapped[WIDTH];

  // Count register: cleared at once while reset is low, released on a sampling clk edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= C_RESET;
    end else begin
      r_value <= w_next;
    end
  end

  assign value = r_value;
  assign tc    = (r_value == C_MAX_W);

  counter_gray_enc #(
    .WIDTH (WIDTH)
  ) u_gray_enc (
    .i_bin  (r_value),
    .o_gray (gray)
  );

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: three configurations share clk and reset;
// the stimulus process pushes expected outputs, the monitor pops them at the
// falling edge and compares.
module tb_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] val_a, gray_a, val_b, gray_b, val_c, gray_c;
  logic       tc_a, tc_b, tc_c;

  counter dut_a (.value(val_a), .clk(clk), .reset(reset), .tc(tc_a), .gray(gray_a));
  counter #(.WIDTH(4), .MAX(9)) dut_b (.value(val_b), .clk(clk), .reset(reset), .tc(tc_b), .gray(gray_b));
  counter #(.WIDTH(4), .MAX(9), .STEP(3)) dut_c (.value(val_c), .clk(clk), .reset(reset), .tc(tc_c), .gray(gray_c));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] v;
    logic       t;
    logic [3:0] g;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
    obs_t c;
  } exp_t;

  typedef enum int {A_NONE, A_HIGH, A_LOW, A_PULSE} act_t;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  bit          running      = 1'b0;
  int unsigned n_edges      = 0;  // counting edges since the last clear

  // Reference: after n counting edges the value is (n*STEP) mod (MAX+1)
  function automatic obs_t model(input int unsigned n, input int unsigned mx, input int unsigned st);
    obs_t o;
    o.v = 4'((n * st) % (mx + 1));
    o.t = (32'(o.v) == mx);
    o.g = o.v ^ (o.v >> 1);
    return o;
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // One clock cycle of stimulus: account for the edge, apply a reset action, push expectation
  task automatic step(input act_t a);
    exp_t e;
    @(posedge clk);
    if (reset === 1'b1) n_edges++;
    #2;
    case (a)
      A_HIGH:  reset = 1'b1;
      A_LOW:   begin reset = 1'b0; n_edges = 0; end
      A_PULSE: begin reset = 1'b0; n_edges = 0; #2; reset = 1'b1; end
      default: ;
    endcase
    e.a = model(n_edges, 15, 1);
    e.b = model(n_edges, 9, 1);
    e.c = model(n_edges, 9, 3);
    exp_q.push_back(e);
    running = 1'b1;
  endtask

  // Monitor: every falling edge the counters present a value; compare to the oldest expectation
  initial begin
    exp_t        e;
    logic [31:0] pg;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (running) begin
          tests_run++;
          tests_failed++;
          $display("FAIL no_expectation t=%0t got empty queue expected an entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        check("val_a",  val_a,        e.a.v);
        check("tc_a",   {3'b0, tc_a}, {3'b0, e.a.t});
        check("gray_a", gray_a,       e.a.g);
        check("val_b",  val_b,        e.b.v);
        check("tc_b",   {3'b0, tc_b}, {3'b0, e.b.t});
        check("gray_b", gray_b,       e.b.g);
        check("val_c",  val_c,        e.c.v);
        check("tc_c",   {3'b0, tc_c}, {3'b0, e.c.t});
        check("gray_c", gray_c,       e.c.g);
        pg = bin2gray(32'(e.a.v));
        check("pkg_bin2gray", pg[3:0], e.a.g);
      end
    end
  end

  // Stimulus: directed reset/count scenarios, then a randomized run with reset pulses
  initial begin
    int unsigned r;
    reset = 1'b0;
    repeat (3) step(A_NONE);
    step(A_HIGH);
    repeat (17) step(A_NONE);
    repeat (4) step(A_NONE);
    step(A_LOW);
    step(A_HIGH);
    repeat (3) step(A_NONE);
    step(A_LOW);
    step(A_HIGH);
    repeat (3) step(A_NONE);
    step(A_LOW);
    step(A_HIGH);
    repeat (3) step(A_NONE);
    step(A_PULSE);
    repeat (12) step(A_NONE);
    step(A_PULSE);
    repeat (3) step(A_NONE);
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 99);
      if (reset == 1'b0) begin
        if (r < 50) step(A_HIGH);
        else        step(A_NONE);
      end else if (r < 3) begin
        step(A_PULSE);
      end else if (r < 6) begin
        step(A_LOW);
      end else begin
        step(A_NONE);
      end
    end
    @(negedge clk);
    #1;
    running = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL leftover_expectations got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
